// File: rtl/usb_fs_in_rr_arb.sv
// Purpose : round-robin, grant-locking arbiter sharing the IN PE 8-bit data path between IN endpoints.
// Latency : grant registered 1 clk after req is sampled; data mux is combinational off the registered grant.
// Backpr. : an owner keeps the path until it drops req; at least one grant-free cycle between owners.
//
// Ports
//   clk            48 MHz system clock
//   reset_n        asynchronous active-low reset (drops any grant immediately)
//   in_ep_req      per-endpoint request, level, held for as long as the endpoint owns the path
//   in_ep_grant    one-hot (or zero) registered grant
//   in_ep_data     per-endpoint data, EP i at [8i+7:8i]
//   arb_in_ep_data data of the granted endpoint, 8'h00 when nothing is granted
//   arb_busy       high while any grant is asserted
//   arb_owner      index of the granted endpoint, 0 when nothing is granted
//   timeout_evt    one-cycle pulse when a grant is revoked by the hold timeout
//
// Build option: define USB_ARB_TIMEOUT_EN to bound how long one grant may be held
// (TIMEOUT_CYCLES). The revoked endpoint is then locked out until it drops its
// request once. Without the macro a grant is held indefinitely and timeout_evt is 0.

module usb_fs_in_rr_arb #(
    parameter int NUM_IN_EPS     = 5,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_IN_EPS-1:0]   in_ep_req,
    output logic [NUM_IN_EPS-1:0]   in_ep_grant,
    input  logic [NUM_IN_EPS*8-1:0] in_ep_data,
    output logic [7:0]              arb_in_ep_data,
    output logic                    arb_busy,
    output logic [3:0]              arb_owner,
    output logic                    timeout_evt
);

    // After reset the pointer sits on the last endpoint so EP0 is searched first.
    localparam logic [3:0] LAST_INIT = 4'(NUM_IN_EPS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                r_state;
    logic [NUM_IN_EPS-1:0] r_grant;
    logic [3:0]            r_owner;
    logic                  r_busy;
    logic                  r_timeout_evt;
    logic [3:0]            r_last_ptr;

    logic [NUM_IN_EPS-1:0] w_elig;
    logic                  w_sel_vld;
    logic [3:0]            w_sel_idx;
    logic [NUM_IN_EPS-1:0] w_sel_onehot;
    logic                  w_owner_req;
    logic [7:0]            w_data;

`ifdef USB_ARB_TIMEOUT_EN
    localparam int               CNT_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [NUM_IN_EPS-1:0] r_block_mask;
    logic [CNT_W-1:0]      r_hold_cnt;

    // A timed-out endpoint stays ineligible until it has dropped its request once.
    assign w_elig = in_ep_req & ~r_block_mask;
`else
    // TIMEOUT_CYCLES only matters in the timeout build; kept so both builds
    // share one parameter list.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_param_unused
    end

    assign w_elig = in_ep_req;
`endif

    // The owner's own request, picked out via the one-hot grant so no index
    // can fall outside the request vector.
    assign w_owner_req = |(in_ep_req & r_grant);

    // Rotating search starting just after the previous owner; first hit wins.
    always_comb begin
        w_sel_vld    = 1'b0;
        w_sel_idx    = '0;
        w_sel_onehot = '0;
        for (int k = 1; k <= NUM_IN_EPS; k++) begin
            automatic int idx = (int'(r_last_ptr) + k) % NUM_IN_EPS;
            if (!w_sel_vld && w_elig[idx]) begin
                w_sel_vld         = 1'b1;
                w_sel_idx         = 4'(idx);
                w_sel_onehot[idx] = 1'b1;
            end
        end
    end

    // Grant is one-hot, so an AND-OR mux is enough and yields 8'h00 when idle.
    always_comb begin
        w_data = 8'h00;
        for (int i = 0; i < NUM_IN_EPS; i++) begin
            if (r_grant[i]) begin
                w_data = w_data | in_ep_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_owner       <= '0;
            r_busy        <= 1'b0;
            r_timeout_evt <= 1'b0;
            r_last_ptr    <= LAST_INIT;
`ifdef USB_ARB_TIMEOUT_EN
            r_block_mask  <= '0;
            r_hold_cnt    <= '0;
`endif
        end else begin
            r_timeout_evt <= 1'b0;
`ifdef USB_ARB_TIMEOUT_EN
            // Any endpoint seen with req low is forgiven.
            r_block_mask  <= r_block_mask & in_ep_req;
`endif
            case (r_state)
                IDLE: begin
                    if (w_sel_vld) begin
                        r_grant    <= w_sel_onehot;
                        r_owner    <= w_sel_idx;
                        r_busy     <= 1'b1;
                        r_state    <= GRANT;
`ifdef USB_ARB_TIMEOUT_EN
                        r_hold_cnt <= '0;
`endif
                    end
                end
                GRANT: begin
                    // Other requests are ignored here; the path is only handed
                    // on by way of IDLE, which guarantees a grant-free cycle.
                    if (!w_owner_req) begin
                        r_grant    <= '0;
                        r_owner    <= '0;
                        r_busy     <= 1'b0;
                        r_last_ptr <= r_owner;
                        r_state    <= IDLE;
`ifdef USB_ARB_TIMEOUT_EN
                    end else if (r_hold_cnt == CNT_MAX) begin
                        r_grant       <= '0;
                        r_owner       <= '0;
                        r_busy        <= 1'b0;
                        r_last_ptr    <= r_owner;
                        r_state       <= IDLE;
                        r_timeout_evt <= 1'b1;
                        r_block_mask  <= (r_block_mask & in_ep_req) | r_grant;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                    r_owner <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ep_grant    = r_grant;
    assign arb_in_ep_data = w_data;
    assign arb_busy       = r_busy;
    assign arb_owner      = r_owner;
    assign timeout_evt    = r_timeout_evt;

endmodule
